backprop_gatherer: RTL and testbench
====================================

BACKPROP_GATHERER -- requirements
Module: backprop_gatherer

Interface
REQ-001 Parameter NUM_SRC, default 4, SHALL set the number of downstream neurons whose change vectors are summed per pass (legal range 1..32).
REQ-002 Parameter AVERAGE, default 0, SHALL select the result: 0 = sum, 1 = sum divided by NUM_SRC.
REQ-003 bg_clock  input  1  SHALL be the single clock; all state updates on its posedge.
REQ-004 bg_reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 bg_start  input  1  SHALL request a new gather pass.
REQ-006 bg_in_valid  input  1  SHALL mark bg_change as holding one downstream neuron's change vector.
REQ-007 bg_in_ready  output  1  SHALL indicate that the block accepts a change vector this cycle.
REQ-008 bg_change  input  real[31:0]  SHALL carry one downstream neuron's per-dendrite backprop change vector.
REQ-009 bg_lane_enabled  input  [31:0]  SHALL mask lanes; a 0 bit forces that lane's contribution to 0.0.
REQ-010 bg_out_valid  output  1  SHALL indicate that bg_backprop holds a completed result.
REQ-011 bg_out_ready  input  1  SHALL indicate that the consumer takes the result.
REQ-012 bg_backprop  output  real[31:0]  SHALL give the backprop value for each upstream neuron (lane i feeds upstream neuron i).
REQ-013 bg_count  output  [5:0]  SHALL give the number of vectors accepted in the current pass.
REQ-014 bg_busy  output  1  SHALL be high in GATHER and HOLD.

Function
REQ-015 The block SHALL implement three states: IDLE, GATHER and HOLD.
REQ-016 IDLE behaviour: bg_in_ready=0 and bg_out_valid=0; bg_start=1 SHALL clear all accumulators to 0.0 and bg_count to 0, then enter GATHER next cycle.
REQ-017 GATHER behaviour: bg_in_ready=1; a beat is accepted when bg_in_valid && bg_in_ready at the posedge.
REQ-018 Accepted beat: acc[i] SHALL become acc[i] + (bg_lane_enabled[i] ? bg_change[i] : 0.0) for all 32 lanes, and bg_count SHALL increment.
REQ-019 Pass completion: the beat that brings bg_count to NUM_SRC SHALL move the FSM to HOLD on the same posedge; the result then includes that beat.
REQ-020 HOLD behaviour: bg_in_ready=0, bg_out_valid=1, and bg_backprop stable; with AVERAGE=1, bg_backprop[i] = acc[i] / NUM_SRC.
REQ-021 Exit from HOLD: bg_out_valid && bg_out_ready SHALL complete the handshake and return to IDLE.
REQ-022 Simultaneous events in HOLD: bg_out_ready=1 and bg_start=1 together SHALL complete the handshake, clear the accumulators and enter GATHER directly.
REQ-023 bg_start SHALL be ignored in GATHER and in HOLD (other than as in REQ-022); the current pass is not restarted.
REQ-024 bg_in_valid SHALL be ignored in IDLE and HOLD; no accumulation occurs.
REQ-025 bg_lane_enabled SHALL be sampled per beat; a mask change mid-pass affects only later beats.
REQ-026 Latency: the last accepted beat SHALL be followed by bg_out_valid=1 on the next cycle; minimum pass length is NUM_SRC+2 cycles from bg_start to bg_out_valid.
REQ-027 Outside HOLD, bg_backprop SHALL show the running accumulator value; it is valid only when bg_out_valid=1.
REQ-028 bg_count SHALL never exceed NUM_SRC; it holds its value in HOLD and clears on entry to GATHER.

Reset
REQ-029 bg_reset=1 at a posedge SHALL force IDLE, all acc to 0.0, bg_count=0, bg_in_ready=0, bg_out_valid=0 and bg_busy=0, overriding every other input.
REQ-030 Reset asserted mid-GATHER or in HOLD SHALL discard the partial or pending result; no output handshake occurs.
REQ-031 After reset deasserts, the block SHALL stay in IDLE until bg_start=1.

Verification
REQ-032 Sum pass (NUM_SRC=4, AVERAGE=0, mask all 1s): start, then 4 beats with lane0 = 1.0, 2.0, 3.0, 4.0 and lane31 = -0.5 each -> bg_out_valid=1 with lane0=10.0, lane31=-2.0, bg_count=4.
REQ-033 Masking and average (AVERAGE=1, NUM_SRC=4, bit 3 of the mask set to 0 for beat 2 only): every lane = 2.0 on all beats -> lane3=1.5 and other lanes 2.0.
REQ-034 Gaps and backpressure: bg_in_valid toggled every other cycle, and bg_out_ready held low for 5 cycles -> result unchanged, bg_out_valid held high, and extra beats in HOLD not accumulated.
REQ-035 Back-to-back passes: bg_start and bg_out_ready both high in HOLD -> GATHER next cycle, bg_count=0 and accumulators 0.0.
REQ-036 Reset mid-pass: reset after 2 of 4 beats -> IDLE with all outputs at reset values; a new pass of 4 beats of 1.0 gives 4.0, with no residue from the aborted pass.

Source files
------------

// File: rtl/backprop_gatherer_if.sv
// Handshake and data bundle between a change-vector producer / result consumer and the gatherer.
// Lane values are signed Q16.16 fixed point: 1.0 = 32'h0001_0000.
interface backprop_gatherer_if;
  logic              bg_start;
  logic              bg_in_valid;
  logic              bg_in_ready;
  logic [31:0][31:0] bg_change;
  logic [31:0]       bg_lane_enabled;
  logic              bg_out_valid;
  logic              bg_out_ready;
  logic [31:0][31:0] bg_backprop;
  logic [5:0]        bg_count;
  logic              bg_busy;

  // Producer/consumer side
  modport master (
    output bg_start, bg_in_valid, bg_change, bg_lane_enabled, bg_out_ready,
    input  bg_in_ready, bg_out_valid, bg_backprop, bg_count, bg_busy
  );

  // Gatherer side
  modport slave (
    input  bg_start, bg_in_valid, bg_change, bg_lane_enabled, bg_out_ready,
    output bg_in_ready, bg_out_valid, bg_backprop, bg_count, bg_busy
  );
endinterface

// File: rtl/backprop_gatherer.sv
// Sums NUM_SRC per-dendrite change vectors lane by lane into 32 backprop values,
// optionally dividing by NUM_SRC, and holds the result until the consumer takes it.
// Lanes are signed Q16.16; accumulators carry extra headroom and the output saturates.
module backprop_gatherer #(
  parameter int unsigned NUM_SRC = 4,
  parameter bit          AVERAGE = 1'b0
) (
  input  logic          bg_clock,
  input  logic          bg_reset,
  backprop_gatherer_if.slave bg_if
);

  localparam int unsigned LANES = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = 6;
  localparam int unsigned AW    = DW + CW;

  localparam logic signed [AW-1:0] L_MAX = AW'(64'sh0000_0000_7FFF_FFFF);
  localparam logic signed [AW-1:0] L_MIN = AW'(-64'sh0000_0000_8000_0000);
  localparam logic signed [AW-1:0] L_DIV = AW'(NUM_SRC);
  localparam logic [CW-1:0]        L_LAST = CW'(NUM_SRC);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GATHER = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t                   r_state;
  logic signed [AW-1:0]     r_acc [LANES];
  logic [CW-1:0]            r_count;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic                     r_busy;
  logic [LANES-1:0][DW-1:0] r_backprop;

  logic signed [AW-1:0]     w_lane_in  [LANES];
  logic signed [AW-1:0]     w_acc_next [LANES];
  logic [LANES-1:0][DW-1:0] w_running;
  logic [LANES-1:0][DW-1:0] w_final;
  logic [LANES-1:0][DW-1:0] w_acc_sat;
  logic                     w_accept;
  logic                     w_last;

  // Clamp a wide accumulator value to the 32-bit lane range
  function automatic logic [DW-1:0] f_sat(input logic signed [AW-1:0] v);
    if (v > L_MAX)      return 32'h7FFF_FFFF;
    else if (v < L_MIN) return 32'h8000_0000;
    else                return DW'(v);
  endfunction

  assign w_accept = r_in_ready && bg_if.bg_in_valid;
  assign w_last   = w_accept && ((r_count + CW'(1)) == L_LAST);

  // Per-lane masked add, running view, and final (optionally averaged) view
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      w_lane_in[i]  = bg_if.bg_lane_enabled[i] ? AW'($signed(bg_if.bg_change[i])) : '0;
      w_acc_next[i] = r_acc[i] + w_lane_in[i];
      w_running[i]  = f_sat(w_acc_next[i]);
      w_final[i]    = AVERAGE ? f_sat(w_acc_next[i] / L_DIV) : w_running[i];
      w_acc_sat[i]  = f_sat(r_acc[i]);
    end
  end

  // Pass control FSM with registered handshake, status and result outputs
  always_ff @(posedge bg_clock) begin
    if (bg_reset) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_backprop  <= '0;
      for (int unsigned i = 0; i < LANES; i++) r_acc[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bg_if.bg_start) begin
            r_state    <= S_GATHER;
            r_count    <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_backprop <= '0;
            for (int unsigned i = 0; i < LANES; i++) r_acc[i] <= '0;
          end
        end
        S_GATHER: begin
          if (w_accept) begin
            r_count <= r_count + CW'(1);
            for (int unsigned i = 0; i < LANES; i++) r_acc[i] <= w_acc_next[i];
            if (w_last) begin
              r_state     <= S_HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_backprop  <= w_final;
            end else begin
              r_backprop  <= w_running;
            end
          end
        end
        S_HOLD: begin
          if (bg_if.bg_out_ready) begin
            r_out_valid <= 1'b0;
            if (bg_if.bg_start) begin
              // Result taken and next pass requested in the same cycle
              r_state    <= S_GATHER;
              r_count    <= '0;
              r_in_ready <= 1'b1;
              r_backprop <= '0;
              for (int unsigned i = 0; i < LANES; i++) r_acc[i] <= '0;
            end else begin
              r_state    <= S_IDLE;
              r_busy     <= 1'b0;
              r_backprop <= w_acc_sat;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bg_if.bg_in_ready  = r_in_ready;
  assign bg_if.bg_out_valid = r_out_valid;
  assign bg_if.bg_busy      = r_busy;
  assign bg_if.bg_count     = r_count;
  assign bg_if.bg_backprop  = r_backprop;

endmodule

// File: tb/tb_backprop_gatherer.sv
// Scoreboard bench: one summing and one averaging gatherer share the same stimulus;
// expected results are queued per instance and checked on each output handshake.
module tb_backprop_gatherer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  backprop_gatherer_if if_a();
  backprop_gatherer_if if_b();

  assign if_b.bg_start        = if_a.bg_start;
  assign if_b.bg_in_valid     = if_a.bg_in_valid;
  assign if_b.bg_change       = if_a.bg_change;
  assign if_b.bg_lane_enabled = if_a.bg_lane_enabled;
  assign if_b.bg_out_ready    = if_a.bg_out_ready;

  backprop_gatherer #(.NUM_SRC(4), .AVERAGE(1'b0)) dut_sum (
    .bg_clock(clk), .bg_reset(rst), .bg_if(if_a));
  backprop_gatherer #(.NUM_SRC(4), .AVERAGE(1'b1)) dut_avg (
    .bg_clock(clk), .bg_reset(rst), .bg_if(if_b));

  typedef struct {
    logic [31:0][31:0] bp;
    logic [5:0]        cnt;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int checks   = 0;
  int failures = 0;

  logic [31:0][31:0] e_sum, e_avg, v;

  function automatic logic [31:0] fx(input real r);
    return 32'($rtoi(r * 65536.0));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmp_result(input string name, input logic [31:0][31:0] act_bp,
                            input logic [5:0] act_cnt, input exp_t e);
    checks++;
    if (act_bp !== e.bp) begin
      failures++;
      for (int i = 0; i < 32; i++)
        if (act_bp[i] !== e.bp[i]) begin
          $display("FAIL %s lane %0d: got %h expected %h", name, i, act_bp[i], e.bp[i]);
          break;
        end
    end
    chk({name, "_count"}, 64'(act_cnt), 64'(e.cnt));
  endtask

  // Monitor: summing instance
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (!rst && if_a.bg_out_valid && if_a.bg_out_ready) begin
      if (q_a.size() == 0) begin
        checks++; failures++;
        $display("FAIL sum_unexpected_result: got handshake expected none");
      end else begin
        e = q_a.pop_front();
        cmp_result("sum_result", if_a.bg_backprop, if_a.bg_count, e);
      end
    end
  end

  // Monitor: averaging instance
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (!rst && if_b.bg_out_valid && if_b.bg_out_ready) begin
      if (q_b.size() == 0) begin
        checks++; failures++;
        $display("FAIL avg_unexpected_result: got handshake expected none");
      end else begin
        e = q_b.pop_front();
        cmp_result("avg_result", if_b.bg_backprop, if_b.bg_count, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp();
    exp_t e;
    e.cnt = 6'd4;
    e.bp = e_sum; q_a.push_back(e);
    e.bp = e_avg; q_b.push_back(e);
  endtask

  task automatic drive_beat(input logic [31:0][31:0] vec, input logic [31:0] mask);
    if_a.bg_in_valid     = 1'b1;
    if_a.bg_change       = vec;
    if_a.bg_lane_enabled = mask;
    tick();
    if_a.bg_in_valid     = 1'b0;
  endtask

  task automatic start_pass();
    if_a.bg_start = 1'b1;
    tick();
    if_a.bg_start = 1'b0;
  endtask

  task automatic take_result();
    if_a.bg_out_ready = 1'b1;
    tick();
    if_a.bg_out_ready = 1'b0;
  endtask

  // status word: {in_ready, out_valid, busy, count}
  function automatic logic [8:0] st_a();
    return {if_a.bg_in_ready, if_a.bg_out_valid, if_a.bg_busy, if_a.bg_count};
  endfunction
  function automatic logic [8:0] st_b();
    return {if_b.bg_in_ready, if_b.bg_out_valid, if_b.bg_busy, if_b.bg_count};
  endfunction

  initial begin
    rst = 1'b1;
    if_a.bg_start = 1'b0;
    if_a.bg_in_valid = 1'b0;
    if_a.bg_change = '0;
    if_a.bg_lane_enabled = '1;
    if_a.bg_out_ready = 1'b0;
    tick(); tick();
    chk("reset_status_sum", 64'(st_a()), 64'(9'b000_000000));
    chk("reset_status_avg", 64'(st_b()), 64'(9'b000_000000));
    chk("reset_backprop", 64'(if_a.bg_backprop[0]), 64'h0);
    rst = 1'b0;
    tick();
    chk("idle_after_reset", 64'(st_a()), 64'(9'b000_000000));

    // Sum pass: lane0 = 1..4, lane31 = -0.5 each
    e_sum = '0; e_avg = '0;
    e_sum[0] = fx(10.0); e_sum[31] = fx(-2.0);
    e_avg[0] = fx(2.5);  e_avg[31] = fx(-0.5);
    push_exp();
    start_pass();
    chk("gather_entry", 64'(st_a()), 64'(9'b101_000000));
    for (int k = 1; k <= 4; k++) begin
      v = '0; v[0] = fx(real'(k)); v[31] = fx(-0.5);
      drive_beat(v, '1);
    end
    chk("hold_after_last_beat", 64'(st_a()), 64'(9'b011_000100));
    take_result();
    chk("idle_after_handshake", 64'(st_a()), 64'(9'b000_000100));

    // Masked beat 2 on lane 3, gaps between beats, then backpressure with extra beats
    for (int i = 0; i < 32; i++) begin e_sum[i] = fx(8.0); e_avg[i] = fx(2.0); end
    e_sum[3] = fx(6.0); e_avg[3] = fx(1.5);
    push_exp();
    start_pass();
    for (int k = 1; k <= 4; k++) begin
      for (int i = 0; i < 32; i++) v[i] = fx(2.0);
      drive_beat(v, (k == 2) ? 32'hFFFF_FFF7 : 32'hFFFF_FFFF);
      if_a.bg_change = '1;
      tick();
    end
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < 32; i++) v[i] = fx(7.0);
      if_a.bg_in_valid = 1'b1;
      if_a.bg_change = v;
      tick();
      chk("backpressure_status", 64'(st_a()), 64'(9'b011_000100));
      chk("backpressure_sum_lane3", 64'(if_a.bg_backprop[3]), 64'(fx(6.0)));
      chk("backpressure_avg_lane0", 64'(if_b.bg_backprop[0]), 64'(fx(2.0)));
    end
    if_a.bg_in_valid = 1'b0;
    take_result();

    // Back-to-back: start with out_ready in HOLD
    e_sum = '0; e_avg = '0;
    e_sum[0] = fx(4.0); e_avg[0] = fx(1.0);
    push_exp();
    start_pass();
    for (int k = 0; k < 4; k++) begin
      v = '0; v[0] = fx(1.0);
      drive_beat(v, '1);
    end
    e_sum = '0; e_avg = '0;
    e_sum[5] = fx(12.0); e_avg[5] = fx(3.0);
    push_exp();
    if_a.bg_start = 1'b1;
    if_a.bg_out_ready = 1'b1;
    tick();
    if_a.bg_start = 1'b0;
    if_a.bg_out_ready = 1'b0;
    chk("b2b_gather_status", 64'(st_a()), 64'(9'b101_000000));
    chk("b2b_cleared_sum_lane0", 64'(if_a.bg_backprop[0]), 64'h0);
    chk("b2b_cleared_avg_lane0", 64'(if_b.bg_backprop[0]), 64'h0);
    for (int k = 0; k < 4; k++) begin
      v = '0; v[5] = fx(3.0);
      drive_beat(v, '1);
    end
    take_result();

    // Reset mid-pass discards partial sum; start during gather is ignored
    start_pass();
    for (int k = 0; k < 2; k++) begin
      v = '0; v[0] = fx(5.0);
      drive_beat(v, '1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midpass_reset_status", 64'(st_a()), 64'(9'b000_000000));
    chk("midpass_reset_lane0", 64'(if_a.bg_backprop[0]), 64'h0);
    tick(); tick(); tick();
    chk("stay_idle_no_start", 64'(st_b()), 64'(9'b000_000000));
    for (int i = 0; i < 32; i++) begin e_sum[i] = fx(4.0); e_avg[i] = fx(1.0); end
    push_exp();
    start_pass();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 32; i++) v[i] = fx(1.0);
      if_a.bg_start = (k == 1);
      drive_beat(v, '1);
      if_a.bg_start = 1'b0;
    end
    take_result();

    tick(); tick();
    chk("queue_drained_sum", 64'(q_a.size()), 64'h0);
    chk("queue_drained_avg", 64'(q_b.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
